// File: rtl/wb_alu_master.sv
// wb_alu_master: Wishbone pipelined-mode master that drives an 8-bit ALU slave.
// It takes one command (A, B, op read address) and issues five bus requests:
// write A, write B, read op (triggers the ALU), read result, read flags.
// The result and flags come back on a valid/ready response channel. If the
// final ack does not arrive within TIMEOUT_CYCLES, the sequence is aborted
// and an error response is returned.
module wb_alu_master #(
    parameter logic [7:0] RES_ADDR       = 8'h03,
    parameter logic [7:0] FLAGS_ADDR     = 8'h02,
    parameter int         TIMEOUT_CYCLES = 64
) (
    input  logic       i_clk,
    input  logic       reset_n,
    // command channel
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    input  logic [7:0] i_cmd_a,
    input  logic [7:0] i_cmd_b,
    input  logic [7:0] i_cmd_op,
    // response channel
    output logic       o_rsp_valid,
    input  logic       i_rsp_ready,
    output logic [7:0] o_rsp_result,
    output logic [7:0] o_rsp_flags,
    output logic       o_rsp_err,
    // wishbone master
    output logic       o_wb_cyc,
    output logic       o_wb_stb,
    output logic       o_wb_we,
    output logic [7:0] o_wb_addr,
    output logic [7:0] o_wb_data,
    input  logic       i_wb_ack,
    input  logic       i_wb_stall,
    input  logic [7:0] i_wb_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0] LAST_IDX   = 3'd4;
    localparam logic [2:0] ACK_TOTAL  = 3'd5;

    state_t     state;
    logic [7:0] b_q;
    logic [7:0] op_q;
    logic [2:0] issue_idx;
    logic [2:0] ack_cnt;
    logic [7:0] timer;

    logic [2:0] idx_nxt;
    logic       nxt_we;
    logic [7:0] nxt_addr;
    logic [7:0] nxt_data;
    logic       in_seq;
    logic       ack_in;
    logic       fifth_ack;
    logic       timeout;
    logic       req_taken;

    assign idx_nxt   = issue_idx + 3'd1;
    assign in_seq    = (state == ISSUE) || (state == WAIT);
    // acks only count while a bus cycle is open
    assign ack_in    = in_seq && o_wb_cyc && i_wb_ack;
    assign fifth_ack = ack_in && (ack_cnt == 3'd4);
    // a coincident final ack takes priority over the timeout
    assign timeout   = in_seq && (timer == TIMER_LAST) && !fifth_ack;
    assign req_taken = (state == ISSUE) && o_wb_stb && !i_wb_stall;

    // Request presented after the current one is accepted. Index 0 (write A)
    // is loaded directly from the command at accept time, so A needs no register.
    always_comb begin
        nxt_we   = 1'b0;
        nxt_addr = 8'h00;
        nxt_data = 8'h00;
        case (idx_nxt)
            3'd1: begin
                nxt_we   = 1'b1;
                nxt_addr = 8'h01;
                nxt_data = b_q;
            end
            3'd2:    nxt_addr = op_q;
            3'd3:    nxt_addr = RES_ADDR;
            3'd4:    nxt_addr = FLAGS_ADDR;
            default: ;
        endcase
    end

    // Sequencer FSM: all bus and response outputs are registered here.
    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            b_q          <= 8'h00;
            op_q         <= 8'h00;
            issue_idx    <= 3'd0;
            ack_cnt      <= 3'd0;
            timer        <= 8'h00;
            o_cmd_ready  <= 1'b1;
            o_rsp_valid  <= 1'b0;
            o_rsp_result <= 8'h00;
            o_rsp_flags  <= 8'h00;
            o_rsp_err    <= 1'b0;
            o_wb_cyc     <= 1'b0;
            o_wb_stb     <= 1'b0;
            o_wb_we      <= 1'b0;
            o_wb_addr    <= 8'h00;
            o_wb_data    <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (i_cmd_valid && o_cmd_ready) begin
                        b_q          <= i_cmd_b;
                        op_q         <= i_cmd_op;
                        issue_idx    <= 3'd0;
                        ack_cnt      <= 3'd0;
                        timer        <= 8'h00;
                        o_rsp_result <= 8'h00;
                        o_rsp_flags  <= 8'h00;
                        o_rsp_err    <= 1'b0;
                        o_cmd_ready  <= 1'b0;
                        o_wb_cyc     <= 1'b1;
                        o_wb_stb     <= 1'b1;
                        o_wb_we      <= 1'b1;
                        o_wb_addr    <= 8'h00;
                        o_wb_data    <= i_cmd_a;
                        state        <= ISSUE;
                    end
                end

                ISSUE, WAIT: begin
                    timer <= timer + 8'h01;

                    // 4th ack carries the result, 5th the flags; others are discarded
                    if (ack_in && (ack_cnt < ACK_TOTAL)) begin
                        ack_cnt <= ack_cnt + 3'd1;
                        if (ack_cnt == 3'd3) o_rsp_result <= i_wb_data;
                        if (ack_cnt == 3'd4) o_rsp_flags  <= i_wb_data;
                    end

                    if (fifth_ack || timeout) begin
                        o_wb_cyc    <= 1'b0;
                        o_wb_stb    <= 1'b0;
                        o_wb_we     <= 1'b0;
                        o_wb_addr   <= 8'h00;
                        o_wb_data   <= 8'h00;
                        o_rsp_valid <= 1'b1;
                        o_rsp_err   <= timeout;
                        state       <= RESP;
                        if (timeout) begin
                            o_rsp_result <= 8'h00;
                            o_rsp_flags  <= 8'h00;
                        end
                    end else if (req_taken) begin
                        if (issue_idx == LAST_IDX) begin
                            // all requests out; keep cyc open for the remaining acks
                            o_wb_stb  <= 1'b0;
                            o_wb_we   <= 1'b0;
                            o_wb_addr <= 8'h00;
                            o_wb_data <= 8'h00;
                            state     <= WAIT;
                        end else begin
                            issue_idx <= idx_nxt;
                            o_wb_we   <= nxt_we;
                            o_wb_addr <= nxt_addr;
                            o_wb_data <= nxt_data;
                        end
                    end
                end

                RESP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        o_cmd_ready <= 1'b1;
                        state       <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
